pwm_deadtime: RTL and testbench

Downstream stage of the PWM generator. It takes the single-ended PWM output and produces a complementary high-side/low-side pair for a half-bridge driver. Both outputs are held low for a programmable dead interval around every transition. It also provides enable gating and a latched fault shutdown; all logic runs in the PWM clock domain.

---
 rtl/pwm_deadtime.sv | 163 ++++++++++++++++
 tb/tb_pwm_deadtime.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: turns the single-ended PWM into a complementary high/low gate
// pair with a programmable dead interval around every transition, enable
// gating and a latched fault shutdown. Everything runs in the PWM clock domain.
// Optional build macro PWM_DT_STATS_EN adds the glitch_cnt statistics output.
module pwm_deadtime #(
  parameter int DT_W       = 8,
  parameter int FAULT_SYNC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pwm_in,
  input  logic            enable,
  input  logic [DT_W-1:0] dead_time,
  input  logic            fault_n,
  input  logic            clear_fault,
`ifdef PWM_DT_STATS_EN
  output logic [15:0]     glitch_cnt,
`endif
  output logic            pwm_hi,
  output logic            pwm_lo,
  output logic            fault_latched
);

  typedef enum logic [2:0] {
    S_OFF,
    S_DEAD_HI,
    S_DEAD_LO,
    S_HI,
    S_LO,
    S_FAULT
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DT_W-1:0]       r_cnt;
  logic [DT_W-1:0]       w_cnt_nxt;
  logic [DT_W-1:0]       r_dt;
  logic [DT_W-1:0]       w_dt_nxt;
  logic [DT_W-1:0]       w_dt_eff;
  logic                  w_glitch;
  logic                  r_pwm_q;
  logic [FAULT_SYNC-1:0] r_fault_sync;
  logic                  w_fault;
  logic                  r_pwm_hi;
  logic                  r_pwm_lo;
  logic                  r_fault_latched;

  // A zero dead time still leaves one cycle with both switches off.
  assign w_dt_eff = (dead_time == '0) ? DT_W'(1) : dead_time;
  assign w_fault  = ~r_fault_sync[FAULT_SYNC-1];

  // Register the incoming PWM once; the FSM only ever looks at r_pwm_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm_q <= 1'b0;
    else        r_pwm_q <= pwm_in;
  end

  // Fault synchroniser; resets to the no-fault level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fault_sync <= '1;
    else        r_fault_sync <= {r_fault_sync[FAULT_SYNC-2:0], fault_n};
  end

  // Next-state logic; every DEAD entry restarts the counter and recaptures dt.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dt_nxt    = r_dt;
    w_glitch    = 1'b0;
    if (w_fault) begin
      w_state_nxt = S_FAULT;
    end else if (r_state == S_FAULT) begin
      // A latched fault is only released by clear_fault, never by enable.
      if (clear_fault) w_state_nxt = S_OFF;
    end else if (!enable) begin
      w_state_nxt = S_OFF;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_nxt = r_pwm_q ? S_DEAD_HI : S_DEAD_LO;
          w_cnt_nxt   = '0;
          w_dt_nxt    = w_dt_eff;
        end
        S_DEAD_HI: begin
          if (!r_pwm_q) begin
            w_state_nxt = S_DEAD_LO;
            w_cnt_nxt   = '0;
            w_dt_nxt    = w_dt_eff;
            w_glitch    = 1'b1;
          end else if (r_cnt == r_dt - DT_W'(1)) begin
            w_state_nxt = S_HI;
          end else begin
            w_cnt_nxt = r_cnt + DT_W'(1);
          end
        end
        S_DEAD_LO: begin
          if (r_pwm_q) begin
            w_state_nxt = S_DEAD_HI;
            w_cnt_nxt   = '0;
            w_dt_nxt    = w_dt_eff;
            w_glitch    = 1'b1;
          end else if (r_cnt == r_dt - DT_W'(1)) begin
            w_state_nxt = S_LO;
          end else begin
            w_cnt_nxt = r_cnt + DT_W'(1);
          end
        end
        S_HI: begin
          if (!r_pwm_q) begin
            w_state_nxt = S_DEAD_LO;
            w_cnt_nxt   = '0;
            w_dt_nxt    = w_dt_eff;
          end
        end
        S_LO: begin
          if (r_pwm_q) begin
            w_state_nxt = S_DEAD_HI;
            w_cnt_nxt   = '0;
            w_dt_nxt    = w_dt_eff;
          end
        end
        default: w_state_nxt = S_OFF;
      endcase
    end
  end

  // State register with outputs decoded from the next state, so they stay exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_OFF;
      r_cnt           <= '0;
      r_dt            <= DT_W'(1);
      r_pwm_hi        <= 1'b0;
      r_pwm_lo        <= 1'b0;
      r_fault_latched <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_dt            <= w_dt_nxt;
      r_pwm_hi        <= (w_state_nxt == S_HI);
      r_pwm_lo        <= (w_state_nxt == S_LO);
      r_fault_latched <= (w_state_nxt == S_FAULT);
    end
  end

  assign pwm_hi        = r_pwm_hi;
  assign pwm_lo        = r_pwm_lo;
  assign fault_latched = r_fault_latched;

`ifdef PWM_DT_STATS_EN
  logic [15:0] r_glitch_cnt;

  // Saturating count of dead intervals abandoned because the target flipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_glitch_cnt <= '0;
    else if (clear_fault)                     r_glitch_cnt <= '0;
    else if (w_glitch && r_glitch_cnt != '1)  r_glitch_cnt <= r_glitch_cnt + 16'd1;
  end

  assign glitch_cnt = r_glitch_cnt;
`endif

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime (default parameters, default build).
module tb_pwm_deadtime;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pwm_in;
  logic       enable;
  logic [7:0] dead_time;
  logic       fault_n;
  logic       clear_fault;
  logic       pwm_hi;
  logic       pwm_lo;
  logic       fault_latched;
`ifdef PWM_DT_STATS_EN
  logic [15:0] glitch_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  pwm_deadtime #(.DT_W(8), .FAULT_SYNC(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pwm_in        (pwm_in),
    .enable        (enable),
    .dead_time     (dead_time),
    .fault_n       (fault_n),
    .clear_fault   (clear_fault),
`ifdef PWM_DT_STATS_EN
    .glitch_cnt    (glitch_cnt),
`endif
    .pwm_hi        (pwm_hi),
    .pwm_lo        (pwm_lo),
    .fault_latched (fault_latched)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n active edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // The two gate drives must never be high together.
  always @(negedge clk) begin
    if (rst_n === 1'b1) chk("overlap", {31'd0, pwm_hi & pwm_lo}, 32'd0);
  end

  initial begin
    rst_n       = 1'b0;
    pwm_in      = 1'b0;
    enable      = 1'b0;
    dead_time   = 8'd4;
    fault_n     = 1'b1;
    clear_fault = 1'b0;
    step(3);
    chk("rst_hi", pwm_hi, 0);
    chk("rst_lo", pwm_lo, 0);
    chk("rst_fault", fault_latched, 0);

    // Startup: OFF -> DEAD_LO for 4 cycles -> LO
    rst_n  = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("start_lo_dead", pwm_lo, 0);
      chk("start_hi", pwm_hi, 0);
    end
    step(1);
    chk("start_lo_on", pwm_lo, 1);

    // Rising edge, dt=4: lo drops after k+1, hi rises after k+5
    pwm_in = 1'b1;
    step(1);
    chk("rise_k_lo", pwm_lo, 1);
    step(1);
    chk("rise_k1_lo", pwm_lo, 0);
    chk("rise_k1_hi", pwm_hi, 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rise_dead_hi", pwm_hi, 0);
    end
    step(1);
    chk("rise_k5_hi", pwm_hi, 1);

    // Falling edge, dt=4
    pwm_in = 1'b0;
    step(1);
    chk("fall_k_hi", pwm_hi, 1);
    step(1);
    chk("fall_k1_hi", pwm_hi, 0);
    step(3);
    chk("fall_k4_lo", pwm_lo, 0);
    step(1);
    chk("fall_k5_lo", pwm_lo, 1);

    // dead_time=0 behaves as one cycle of dead band
    dead_time = 8'd0;
    pwm_in    = 1'b1;
    step(2);
    chk("dt0_r_lo", pwm_lo, 0);
    chk("dt0_r_hi", pwm_hi, 0);
    step(1);
    chk("dt0_r_hi_on", pwm_hi, 1);
    pwm_in = 1'b0;
    step(2);
    chk("dt0_f_hi", pwm_hi, 0);
    chk("dt0_f_lo", pwm_lo, 0);
    step(1);
    chk("dt0_f_lo_on", pwm_lo, 1);

    // 3-cycle high pulse with dt=6 is absorbed; lo returns after restarted interval
    dead_time = 8'd6;
    pwm_in    = 1'b1;
    step(3);
    pwm_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("glitch_hi", pwm_hi, 0);
      chk("glitch_lo", pwm_lo, 0);
    end
    step(1);
    chk("glitch_lo_back", pwm_lo, 1);

    // Reach HI with dt=2
    dead_time = 8'd2;
    pwm_in    = 1'b1;
    step(4);
    chk("pre_fault_hi", pwm_hi, 1);

    // One-cycle fault pulse: outputs off after two edges
    fault_n = 1'b0;
    step(1);
    fault_n = 1'b1;
    chk("flt_e0_hi", pwm_hi, 1);
    step(1);
    chk("flt_e1_hi", pwm_hi, 1);
    step(1);
    chk("flt_e2_hi", pwm_hi, 0);
    chk("flt_e2_lo", pwm_lo, 0);
    chk("flt_e2_latch", fault_latched, 1);

    // clear while fault still active is ignored
    fault_n = 1'b0;
    step(3);
    clear_fault = 1'b1;
    step(1);
    clear_fault = 1'b0;
    chk("clr_active_latch", fault_latched, 1);
    fault_n = 1'b1;
    step(3);
    chk("flt_gone_latch", fault_latched, 1);
    chk("flt_gone_hi", pwm_hi, 0);

    // clear after fault gone: OFF, then dead interval, then HI
    clear_fault = 1'b1;
    step(1);
    clear_fault = 1'b0;
    chk("clr_latch", fault_latched, 0);
    chk("clr_hi", pwm_hi, 0);
    step(2);
    chk("clr_dead_hi", pwm_hi, 0);
    step(1);
    chk("clr_resume_hi", pwm_hi, 1);

    // enable dropped during HI, then re-enabled
    enable = 1'b0;
    step(1);
    chk("dis_hi", pwm_hi, 0);
    chk("dis_lo", pwm_lo, 0);
    enable = 1'b1;
    step(2);
    chk("reen_dead_hi", pwm_hi, 0);
    step(1);
    chk("reen_hi", pwm_hi, 1);

    // Asynchronous reset while HI drops the output between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_hi", pwm_hi, 0);
    step(1);
    rst_n = 1'b1;
    step(4);
    chk("post_rst_hi", pwm_hi, 1);

    // Reset pulsed mid-DEAD, then a full dead interval from OFF
    dead_time = 8'd8;
    pwm_in    = 1'b0;
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("dead_rst_hi", pwm_hi, 0);
    chk("dead_rst_lo", pwm_lo, 0);
    chk("dead_rst_latch", fault_latched, 0);
    step(1);
    rst_n = 1'b1;
    step(8);
    chk("dead_rst_e8_lo", pwm_lo, 0);
    step(1);
    chk("dead_rst_e9_lo", pwm_lo, 1);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
